// File: rtl/tsu_sched_pkg.sv
// Shared types and constants for the tsu timestamp scheduler.
//   sched_state_e : scheduler FSM states
//   sched_rsp_t   : response payload (id, phase, err), sized for the widest build
//   *_DEF         : default counter widths and cycle counts
package tsu_sched_pkg;

  localparam int unsigned RSP_ID_BITS    = 4;   // covers NREQ up to 16
  localparam int unsigned RSP_PHASE_BITS = 64;  // covers any practical RAT_PREC_BITS

  localparam int unsigned GAP_BITS_DEF = 16;
  localparam int unsigned TMO_BITS_DEF = 16;
  localparam logic [GAP_BITS_DEF-1:0] GAP_CYCS_DEF = GAP_BITS_DEF'(8);
  localparam logic [TMO_BITS_DEF-1:0] TMO_CYCS_DEF = TMO_BITS_DEF'(1024);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_MARK,
    ST_WAIT_PH,
    ST_GAP
  } sched_state_e;

  typedef struct packed {
    logic [RSP_ID_BITS-1:0]    id;
    logic [RSP_PHASE_BITS-1:0] phase;
    logic                      err;
  } sched_rsp_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin priority picker.
//   i_req    : request vector
//   i_adv    : advance pointer past i_adv_id this cycle
//   i_adv_id : id just served
//   o_any_c  : some request is pending (combinational)
//   o_pick_c : first requester at or after the pointer, with wrap (combinational)
module rr_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ID_BITS = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    i_req,
  input  logic               i_adv,
  input  logic [ID_BITS-1:0] i_adv_id,
  output logic               o_any_c,
  output logic [ID_BITS-1:0] o_pick_c
);

  localparam int unsigned SW = ID_BITS + 1;

  logic [ID_BITS-1:0] r_ptr;
  logic [SW-1:0]      w_idx;

  // Scan upward from the pointer; one extra bit keeps the wrap arithmetic exact.
  always_comb begin
    o_any_c  = 1'b0;
    o_pick_c = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + SW'(k);
      if (w_idx >= SW'(NREQ)) w_idx = w_idx - SW'(NREQ);
      if (!o_any_c && i_req[w_idx[ID_BITS-1:0]]) begin
        o_any_c  = 1'b1;
        o_pick_c = w_idx[ID_BITS-1:0];
      end
    end
  end

  // Pointer moves just past the served requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (i_adv_id == ID_BITS'(NREQ - 1)) ? '0 : i_adv_id + ID_BITS'(1);
    end
  end

endmodule

// File: rtl/tsu_ts_sched.sv
// Shares one tsu phase-measurement path among NREQ timestamp requesters.
//   i_req/o_gnt        : level requests, one-cycle one-hot grant (marker issue cycle)
//   i_locked           : tsu tracking valid; gates all issue
//   i_gap_cycs         : min cycles from result/timeout to next marker
//   i_tmo_cycs         : result timeout, 0 = wait forever
//   o_mark             : one-cycle marker command
//   i_phase/i_phase_v  : tsu phase result
//   o_rsp_*            : tagged response, err on timeout or lock loss
//   o_busy             : a marker transaction is in flight
module tsu_ts_sched
  import tsu_sched_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned ID_BITS       = $clog2(NREQ),
  parameter int unsigned RAT_PREC_BITS = 32,
  parameter int unsigned GAP_BITS      = GAP_BITS_DEF,
  parameter int unsigned TMO_BITS      = TMO_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          i_req,
  output logic [NREQ-1:0]          o_gnt,
  input  logic                     i_locked,
  input  logic [GAP_BITS-1:0]      i_gap_cycs,
  input  logic [TMO_BITS-1:0]      i_tmo_cycs,
  output logic                     o_mark,
  input  logic [RAT_PREC_BITS-1:0] i_phase,
  input  logic                     i_phase_v,
  output logic                     o_rsp_v,
  output logic [ID_BITS-1:0]       o_rsp_id,
  output logic [RAT_PREC_BITS-1:0] o_rsp_phase,
  output logic                     o_rsp_err,
  output logic                     o_busy
);

  sched_state_e       r_state;
  logic [ID_BITS-1:0] r_id;
  logic [NREQ-1:0]    r_gnt;
  logic               r_mark;
  logic               r_busy;
  logic               r_rsp_v;
  sched_rsp_t         r_rsp;
  logic [TMO_BITS-1:0] r_tmo;
  logic [GAP_BITS-1:0] r_gap;

  logic               w_any;
  logic [ID_BITS-1:0] w_pick;
  logic               w_adv;
  logic               w_rsp_unused;

  assign w_adv = (r_state == ST_MARK);

  rr_arb #(
    .NREQ    (NREQ),
    .ID_BITS (ID_BITS)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_adv    (w_adv),
    .i_adv_id (r_id),
    .o_any_c  (w_any),
    .o_pick_c (w_pick)
  );

  // Scheduler FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT_LOCK;
      r_id    <= '0;
      r_gnt   <= '0;
      r_mark  <= 1'b0;
      r_busy  <= 1'b0;
      r_rsp_v <= 1'b0;
      r_rsp   <= '0;
      r_tmo   <= '0;
      r_gap   <= '0;
    end else begin
      r_gnt   <= '0;
      r_mark  <= 1'b0;
      r_rsp_v <= 1'b0;
      case (r_state)
        ST_WAIT_LOCK: begin
          if (i_locked) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!i_locked) begin
            r_state <= ST_WAIT_LOCK;
          end else if (w_any) begin
            // Grant and marker are raised so they are visible during MARK.
            r_id    <= w_pick;
            r_gnt   <= NREQ'(1) << w_pick;
            r_mark  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_MARK;
          end
        end
        ST_MARK: begin
          r_tmo   <= i_tmo_cycs;
          r_state <= ST_WAIT_PH;
        end
        ST_WAIT_PH: begin
          if (i_phase_v) begin
            r_rsp_v <= 1'b1;
            r_rsp   <= '{id: RSP_ID_BITS'(r_id), phase: RSP_PHASE_BITS'(i_phase), err: 1'b0};
            r_gap   <= i_gap_cycs;
            r_state <= ST_GAP;
          end else if (!i_locked) begin
            r_rsp_v <= 1'b1;
            r_rsp   <= '{id: RSP_ID_BITS'(r_id), phase: '0, err: 1'b1};
            r_busy  <= 1'b0;
            r_state <= ST_WAIT_LOCK;
          end else if (r_tmo != '0 && r_tmo <= TMO_BITS'(2)) begin
            // Fires so the error response lands i_tmo_cycs cycles after the marker.
            r_rsp_v <= 1'b1;
            r_rsp   <= '{id: RSP_ID_BITS'(r_id), phase: '0, err: 1'b1};
            r_gap   <= i_gap_cycs;
            r_state <= ST_GAP;
          end else if (r_tmo != '0) begin
            r_tmo <= r_tmo - TMO_BITS'(1);
          end
        end
        ST_GAP: begin
          // max(i_gap_cycs,1) cycles spent here.
          if (!i_locked) begin
            r_busy  <= 1'b0;
            r_state <= ST_WAIT_LOCK;
          end else if (r_gap <= GAP_BITS'(1)) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap - GAP_BITS'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_mark      = r_mark;
  assign o_busy      = r_busy;
  assign o_rsp_v     = r_rsp_v;
  assign o_rsp_id    = r_rsp.id[ID_BITS-1:0];
  assign o_rsp_phase = r_rsp.phase[RAT_PREC_BITS-1:0];
  assign o_rsp_err   = r_rsp.err;

  // Payload is sized for the widest build; upper bits stay zero.
  assign w_rsp_unused = ^r_rsp;

endmodule

// File: tb/tb_tsu_ts_sched.sv
// Self-checking bench for tsu_ts_sched: scoreboard of expected responses.
module tb_tsu_ts_sched;
  import tsu_sched_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  i_req;
  logic [3:0]  o_gnt;
  logic        i_locked;
  logic [15:0] i_gap_cycs;
  logic [15:0] i_tmo_cycs;
  logic        o_mark;
  logic [31:0] i_phase;
  logic        i_phase_v;
  logic        o_rsp_v;
  logic [1:0]  o_rsp_id;
  logic [31:0] o_rsp_phase;
  logic        o_rsp_err;
  logic        o_busy;

  typedef struct {
    int          id;
    logic [31:0] ph;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_mark = 0;
  int   n_rsp = 0;
  int   n_abort = 0;

  tsu_ts_sched dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .o_gnt       (o_gnt),
    .i_locked    (i_locked),
    .i_gap_cycs  (i_gap_cycs),
    .i_tmo_cycs  (i_tmo_cycs),
    .o_mark      (o_mark),
    .i_phase     (i_phase),
    .i_phase_v   (i_phase_v),
    .o_rsp_v     (o_rsp_v),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_phase (o_rsp_phase),
    .o_rsp_err   (o_rsp_err),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: every response must match the oldest expected entry.
  task automatic mon();
    exp_t e;
    if (o_mark) n_mark++;
    if (o_rsp_v) begin
      n_rsp++;
      check("rsp_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("rsp_id", 64'(o_rsp_id), 64'(e.id));
        check("rsp_err", 64'(o_rsp_err), 64'(e.err));
        check("rsp_phase", 64'(o_rsp_phase), 64'(e.ph));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mon();
  endtask

  task automatic push(input int id, input logic [31:0] ph, input logic err);
    exp_t e;
    e.id = id; e.ph = ph; e.err = err;
    q.push_back(e);
  endtask

  task automatic wait_mark(input int bound, output int m);
    int k;
    k = 0;
    tick();
    while (!o_mark && k < bound) begin
      tick();
      k++;
    end
    check("mark_seen", 64'(o_mark), 64'd1);
    m = cyc;
  endtask

  task automatic wait_rsp(input int bound);
    int k;
    k = 0;
    tick();
    while (!o_rsp_v && k < bound) begin
      tick();
      k++;
    end
    check("rsp_seen", 64'(o_rsp_v), 64'd1);
  endtask

  initial begin
    int m;
    int prev;
    int mk0;
    int rs0;
    logic [3:0] exp_gnt;

    rst = 1'b1; i_req = '0; i_locked = 1'b0; i_phase = '0; i_phase_v = 1'b0;
    i_gap_cycs = GAP_CYCS_DEF; i_tmo_cycs = TMO_CYCS_DEF;
    repeat (3) tick();
    check("rst_gnt", 64'(o_gnt), 64'd0);
    check("rst_mark", 64'(o_mark), 64'd0);
    check("rst_rsp_v", 64'(o_rsp_v), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_rsp_phase", 64'(o_rsp_phase), 64'd0);

    // Round-robin with all requesting, result 10 cycles after each marker.
    rst = 1'b0; i_gap_cycs = 16'd5; i_tmo_cycs = 16'd0; i_req = 4'b1111; i_locked = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_mark(60, m);
      exp_gnt = 4'b0001 << (i % 4);
      check("rr_gnt", 64'(o_gnt), 64'(exp_gnt));
      check("rr_busy", 64'(o_busy), 64'd1);
      if (i > 0) check("rr_spacing", 64'(m - prev), 64'd17);
      prev = m;
      repeat (10) tick();
      i_phase = 32'hA000_0000 + 32'(i); i_phase_v = 1'b1;
      push(i % 4, i_phase, 1'b0);
      tick();
      i_phase_v = 1'b0;
      check("rsp_latency", 64'(o_rsp_v), 64'd1);
    end

    // Unlocked: request held but never issued; grant 2 cycles after lock.
    i_locked = 1'b0; i_req = 4'b0010;
    mk0 = n_mark;
    repeat (50) tick();
    check("nolock_marks", 64'(n_mark - mk0), 64'd0);
    i_locked = 1'b1;
    tick();
    tick();
    check("relock_gnt", 64'(o_gnt), 64'b0010);
    check("relock_mark", 64'(o_mark), 64'd1);
    i_req = '0;

    // Lock drops 3 cycles into the result wait.
    repeat (3) tick();
    i_locked = 1'b0;
    push(1, 32'd0, 1'b1);
    wait_rsp(10);
    check("lockloss_busy", 64'(o_busy), 64'd0);
    i_req = 4'b0100;
    mk0 = n_mark;
    repeat (20) tick();
    check("lockloss_nomark", 64'(n_mark - mk0), 64'd0);

    // Timeout after 20 cycles; late result must be dropped.
    i_tmo_cycs = 16'd20; i_locked = 1'b1;
    wait_mark(10, m);
    check("tmo_gnt", 64'(o_gnt), 64'b0100);
    i_req = '0;
    push(2, 32'd0, 1'b1);
    wait_rsp(40);
    check("tmo_delay", 64'(cyc - m), 64'd20);
    rs0 = n_rsp;
    repeat (5) tick();
    i_phase = 32'hDEAD_BEEF; i_phase_v = 1'b1;
    tick();
    i_phase_v = 1'b0;
    repeat (10) tick();
    check("late_dropped", 64'(n_rsp - rs0), 64'd0);

    // Result on the same cycle the timeout expires wins.
    i_req = 4'b0001;
    wait_mark(20, m);
    check("same_gnt", 64'(o_gnt), 64'b0001);
    i_req = '0;
    repeat (19) tick();
    rs0 = n_rsp;
    i_phase = 32'h1234; i_phase_v = 1'b1;
    push(0, 32'h1234, 1'b0);
    tick();
    i_phase_v = 1'b0;
    check("same_rsp_v", 64'(o_rsp_v), 64'd1);
    repeat (10) tick();
    check("same_single", 64'(n_rsp - rs0), 64'd1);

    // Reset in the middle of a result wait.
    i_req = 4'b0100; i_tmo_cycs = 16'd0;
    wait_mark(20, m);
    check("pre_rst_gnt", 64'(o_gnt), 64'b0100);
    i_req = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_abort++;
    check("midrst_rsp_v", 64'(o_rsp_v), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_gnt", 64'(o_gnt), 64'd0);
    rst = 1'b0; i_req = 4'b1000;
    wait_mark(10, m);
    check("postrst_gnt", 64'(o_gnt), 64'b1000);
    i_req = '0;
    repeat (10) tick();
    i_phase = 32'h5555_AAAA; i_phase_v = 1'b1;
    push(3, 32'h5555_AAAA, 1'b0);
    tick();
    i_phase_v = 1'b0;
    repeat (20) tick();

    check("queue_empty", 64'(q.size()), 64'd0);
    check("one_rsp_per_mark", 64'(n_rsp), 64'(n_mark - n_abort));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tsu_ts_sched.md
Name: tsu_ts_sched

Overview:
- Scheduler in the 1588 clock domain that shares one tsu phase-measurement path among NREQ timestamp requesters.
- Round-robin arbitration picks one pending requester and issues a one-cycle marker command to the marker generation path. It then waits for the tsu phase result, tags it with the requester id and returns it.
- Enforces a minimum spacing between markers, a timeout on missing results, and gating until the tsu reports lock.

Parameters:
- NREQ, 4, number of requesters (2..16).
- ID_BITS, $clog2(NREQ), width of requester id.
- RAT_PREC_BITS, 32, width of tsu phase word.
- GAP_BITS, 16, width of minimum inter-marker gap counter.
- TMO_BITS, 16, width of result timeout counter.

Ports:
- clk  in  1  1588 clock.
- rst  in  1  synchronous, active-high reset.
- i_req  in  NREQ  per-requester level request; held until its o_gnt pulse.
- o_gnt  out  NREQ  one-hot, one-cycle grant; the cycle of the pulse is the marker issue cycle.
- i_locked  in  1  tsu ratio/phase tracking valid.
- i_gap_cycs  in  GAP_BITS  minimum clk cycles from a result (or timeout) to the next marker.
- i_tmo_cycs  in  TMO_BITS  clk cycles to wait for i_phase_v after o_mark; 0 means wait forever.
- o_mark  out  1  one-cycle marker command toward the fclk marker path.
- i_phase  in  RAT_PREC_BITS  tsu phase result.
- i_phase_v  in  1  i_phase valid, single cycle.
- o_rsp_v  out  1  response valid, single cycle.
- o_rsp_id  out  ID_BITS  requester id for the response.
- o_rsp_phase  out  RAT_PREC_BITS  captured phase; 0 on error.
- o_rsp_err  out  1  response is a timeout or lock-loss abort.
- o_busy  out  1  high in any state other than IDLE and WAIT_LOCK.

Behaviour:
- Reset values: all outputs 0; state WAIT_LOCK; round-robin pointer 0; counters 0.
- FSM states: WAIT_LOCK, IDLE, MARK, WAIT_PH, GAP.
- WAIT_LOCK -> IDLE when i_locked=1. Requests are ignored, not dropped (i_req is a level).
- IDLE -> MARK when i_locked and |i_req.
  - Winner is the first set bit at or after the pointer, scanning upward with wrap.
  - Winner id is registered.
  - IDLE -> WAIT_LOCK if i_locked=0.
- MARK, one cycle:
  - o_mark=1 and o_gnt[id]=1.
  - Pointer <= id+1, wrapping to 0 after NREQ-1.
  - Timeout counter loads i_tmo_cycs.
  - -> WAIT_PH.
- WAIT_PH:
  - On i_phase_v: o_rsp_v=1 next cycle with o_rsp_id=id, o_rsp_phase=i_phase, o_rsp_err=0; -> GAP.
  - On timeout counter reaching 1 (decremented each cycle, only when i_tmo_cycs!=0): o_rsp_v=1, o_rsp_err=1, o_rsp_phase=0; -> GAP.
  - On i_locked falling: o_rsp_v=1, o_rsp_err=1; -> WAIT_LOCK.
  - Priority when events coincide: i_phase_v > lock loss > timeout. A result arriving on the timeout cycle is accepted.
- GAP:
  - Counter loads i_gap_cycs on entry; -> IDLE when it reaches 0. i_gap_cycs=0 gives exactly one GAP cycle.
  - If i_locked falls, -> WAIT_LOCK.
- Latency: request sampled in IDLE -> o_gnt/o_mark in the next cycle. i_phase_v -> o_rsp_v one cycle later.
- Minimum issue period: 1 (MARK) + result wait + 1 + max(i_gap_cycs,1) cycles.
- An i_phase_v seen outside WAIT_PH is dropped (stale result), with no response.
- Exactly one o_rsp_v per o_mark, always.
- Request deassertion before grant is legal; the scan is recomputed every IDLE cycle.
- Config inputs are sampled only on counter load; changes mid-count take effect at the next load.
- Reset asserted mid-operation: outputs cleared next edge, no response emitted, pointer cleared.

Decomposition:
- Package tsu_sched_pkg holds:
  - the state enum typedef;
  - the response struct typedef (id, phase, err);
  - default GAP/TMO constants.
- Sub-module rr_arb (NREQ-wide round-robin priority picker, combinational plus a registered pointer). It is reusable for other tsu-side arbitration.

Test Plan:
- NREQ=4, i_locked=1, i_req=4'b1111 held, gap=5, result returned 10 cycles after each o_mark -> grants in order id 0,1,2,3,0. Each o_rsp_id matches the grant. Consecutive o_mark pulses are exactly 1+10+1+5 cycles apart.
- i_locked=0 with i_req=4'b0010 for 50 cycles, then i_locked=1 -> no o_mark during the 50 cycles; o_gnt[1] 2 cycles after lock rises.
- i_tmo_cycs=20, no i_phase_v -> o_rsp_v with err=1, phase=0, 20 cycles after o_mark. A late i_phase_v at 25 cycles produces no response.
- i_phase_v on the same cycle the timeout expires, phase=32'h1234 -> single response, err=0, phase=32'h1234.
- i_locked drops 3 cycles into WAIT_PH -> one err response, FSM in WAIT_LOCK, no o_mark until relock.
- rst pulsed during WAIT_PH -> all outputs 0 next cycle, no o_rsp_v. After release with i_req=4'b1000, the pointer scan starts at 0 and id 3 is granted.
